priority_encoder: RTL and testbench

- 4-input to 2-bit priority encoder with registered outputs and a valid flag.
- Highest-numbered asserted input wins (i3 highest, i0 lowest).
- Leaf block used wherever a small one-of-four request set must be reduced to a binary index, e.g. interrupt or request selection.
- The combinational priority logic feeds one output register stage clocked by clk.

---
 rtl/priority_encoder_pkg.sv | 15 +
 rtl/priority_encoder_core.sv | 41 ++++
 rtl/priority_encoder.sv | 65 ++++++
 tb/tb_priority_encoder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// ---------------------------------------------------------------------------
// priority_encoder_pkg
// Shared constants for the 4-input priority encoder.
//   IDX_I0..IDX_I3 : binary index reported when the matching request wins
//   IDX_RESET      : index value held in the output register after reset
// ---------------------------------------------------------------------------
package priority_encoder_pkg;

   localparam logic [1:0] IDX_I0    = 2'b00;
   localparam logic [1:0] IDX_I1    = 2'b01;
   localparam logic [1:0] IDX_I2    = 2'b10;
   localparam logic [1:0] IDX_I3    = 2'b11;
   localparam logic [1:0] IDX_RESET = 2'b00;

endpackage : priority_encoder_pkg

// File: rtl/priority_encoder_core.sv
// ---------------------------------------------------------------------------
// prio_enc4_core
// Purely combinational one-of-four priority reduction. The highest-numbered
// asserted request wins.
// Ports:
//   i0..i3 : request inputs, i3 highest priority
//   idx    : binary index of the winning request (IDX_I0 when none)
//   any    : high when at least one request is asserted
// ---------------------------------------------------------------------------
module prio_enc4_core
   import priority_encoder_pkg::*;
(
   input  logic       i0,
   input  logic       i1,
   input  logic       i2,
   input  logic       i3,
   output logic [1:0] idx,
   output logic       any
);

   // Walk the requests from highest to lowest so a higher request always
   // masks the ones below it. With no request the index falls back to
   // IDX_I0, so downstream logic must qualify idx with any.
   always_comb begin
      idx = IDX_I0;
      any = 1'b1;
      if (i3) begin
         idx = IDX_I3;
      end else if (i2) begin
         idx = IDX_I2;
      end else if (i1) begin
         idx = IDX_I1;
      end else if (i0) begin
         idx = IDX_I0;
      end else begin
         idx = IDX_I0;
         any = 1'b0;
      end
   end

endmodule : prio_enc4_core

// File: rtl/priority_encoder.sv
// ---------------------------------------------------------------------------
// priority_encoder
// 4-input to 2-bit priority encoder with a single registered output stage.
// Outputs reflect the inputs sampled on the previous rising clock edge.
// Ports:
//   clk    : system clock, rising-edge active
//   rst_n  : synchronous active-low reset
//   i0..i3 : requests, i3 highest priority
//   y1, y0 : registered index of the winning request (MSB, LSB)
//   valid  : registered flag, high when any request was asserted
// ---------------------------------------------------------------------------
module priority_encoder
   import priority_encoder_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i0,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   output logic y1,
   output logic y0,
   output logic valid
);

   logic [1:0] core_idx;
   logic       core_any;

   logic [1:0] idx_d;
   logic [1:0] idx_q;
   logic       valid_d;
   logic       valid_q;

   prio_enc4_core u_core (
      .i0  (i0),
      .i1  (i1),
      .i2  (i2),
      .i3  (i3),
      .idx (core_idx),
      .any (core_any)
   );

   // Next-state values come straight from the combinational core; reset is
   // handled in the register so it overrides any request in the same cycle.
   always_comb begin
      idx_d   = core_idx;
      valid_d = core_any;
   end

   // Output register stage with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q   <= IDX_RESET;
         valid_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   assign y1    = idx_q[1];
   assign y0    = idx_q[0];
   assign valid = valid_q;

endmodule : priority_encoder

// File: tb/tb_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_priority_encoder
// Self-checking bench for priority_encoder. A behavioural reference model
// scans the request vector for its highest set bit; outputs are compared one
// clock after each pattern is applied.
// ---------------------------------------------------------------------------
module tb_priority_encoder;

   logic clk;
   logic rst_n;
   logic i0;
   logic i1;
   logic i2;
   logic i3;
   logic y1;
   logic y0;
   logic valid;

   int compareCount;
   int failCount;

   priority_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i0    (i0),
      .i1    (i1),
      .i2    (i2),
      .i3    (i3),
      .y1    (y1),
      .y0    (y0),
      .valid (valid)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: result packed as {index[1:0], valid}. The index is the
   // position of the highest set request bit, or zero when none is set.
   function automatic logic [2:0] refModel(input logic [3:0] req, input logic rstN);
      logic [2:0] result;
      result = 3'b000;
      if (rstN) begin
         for (int k = 0; k < 4; k++) begin
            if (req[k]) begin
               result = {k[1:0], 1'b1};
            end
         end
      end
      return result;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got {y1,y0,valid}=%b, expected %b", tag, observed, expected);
      end
   endtask

   // Drive one pattern away from the active edge, let it be registered, and
   // return just after the edge so outputs can be sampled safely.
   task automatic applyStimulus(input logic rstN, input logic [3:0] req);
      @(negedge clk);
      rst_n = rstN;
      {i3, i2, i1, i0} = req;
      @(posedge clk);
      #1;
   endtask

   // Apply a pattern and compare the registered result against the model.
   task automatic stepAndCheck(input string tag, input logic rstN, input logic [3:0] req);
      applyStimulus(rstN, req);
      checkOutput(tag, {y1, y0, valid}, refModel(req, rstN));
   endtask

   logic [3:0] sweepVec [5];
   logic [3:0] conflictVec [4];
   logic [2:0] heldOut;
   logic [3:0] randReq;

   initial begin
      compareCount = 0;
      failCount    = 0;
      rst_n = 1'b0;
      {i3, i2, i1, i0} = 4'b0000;

      // Reset dominates even with every request asserted.
      applyStimulus(1'b0, 4'b1111);
      checkOutput("reset_edge1", {y1, y0, valid}, 3'b000);
      applyStimulus(1'b0, 4'b1111);
      checkOutput("reset_edge2", {y1, y0, valid}, 3'b000);

      // One-hot sweep with explicit expected values.
      sweepVec = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      applyStimulus(1'b1, sweepVec[0]);
      checkOutput("sweep_0000", {y1, y0, valid}, 3'b000);
      applyStimulus(1'b1, sweepVec[1]);
      checkOutput("sweep_0001", {y1, y0, valid}, 3'b001);
      applyStimulus(1'b1, sweepVec[2]);
      checkOutput("sweep_0010", {y1, y0, valid}, 3'b011);
      applyStimulus(1'b1, sweepVec[3]);
      checkOutput("sweep_0100", {y1, y0, valid}, 3'b101);
      applyStimulus(1'b1, sweepVec[4]);
      checkOutput("sweep_1000", {y1, y0, valid}, 3'b111);

      // Priority conflicts.
      conflictVec = '{4'b0011, 4'b0110, 4'b1001, 4'b1111};
      applyStimulus(1'b1, conflictVec[0]);
      checkOutput("conflict_0011", {y1, y0, valid}, 3'b011);
      applyStimulus(1'b1, conflictVec[1]);
      checkOutput("conflict_0110", {y1, y0, valid}, 3'b101);
      applyStimulus(1'b1, conflictVec[2]);
      checkOutput("conflict_1001", {y1, y0, valid}, 3'b111);
      applyStimulus(1'b1, conflictVec[3]);
      checkOutput("conflict_1111", {y1, y0, valid}, 3'b111);
      applyStimulus(1'b1, 4'b0101);
      checkOutput("conflict_0101", {y1, y0, valid}, 3'b101);

      // Exhaustive pass, each pattern also followed by a mid-cycle input
      // change that must not disturb the registered outputs.
      for (int p = 0; p < 16; p++) begin
         stepAndCheck($sformatf("exh_%04b", p[3:0]), 1'b1, p[3:0]);
         heldOut = {y1, y0, valid};
         {i3, i2, i1, i0} = ~p[3:0];
         #2;
         checkOutput($sformatf("hold_%04b", p[3:0]), {y1, y0, valid}, refModel(p[3:0], 1'b1));
         {i3, i2, i1, i0} = p[3:0];
      end

      // Randomized patterns with occasional reset.
      for (int r = 0; r < 200; r++) begin
         randReq = 4'($urandom_range(0, 15));
         stepAndCheck("random", ($urandom_range(0, 9) != 0), randReq);
      end

      // Reset mid-stream.
      applyStimulus(1'b1, 4'b1000);
      checkOutput("mid_pre", {y1, y0, valid}, 3'b111);
      applyStimulus(1'b0, 4'b1000);
      checkOutput("mid_reset", {y1, y0, valid}, 3'b000);
      applyStimulus(1'b1, 4'b0100);
      checkOutput("mid_release", {y1, y0, valid}, 3'b101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule : tb_priority_encoder
